// File: rtl/adder_result_buffer.sv
`default_nettype none
// ============================================================================
// Module   : adder_result_buffer
// Purpose  : Result FIFO for the pipelined adder, with back-pressure and a
//            running accumulator of every accepted {carry, sum} result.
//            Optional macro RESBUF_FLUSH_EN adds a synchronous flush input.
// Revision : 1.0 - initial release
// ============================================================================
module adder_result_buffer #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    parameter int AW    = 2,
    parameter int ACCW  = 40
) (
    input  logic              clk,
    input  logic              rst,
`ifdef RESBUF_FLUSH_EN
    input  logic              flush,
`endif
    input  logic              validin,
    input  logic [WIDTH-1:0]  sum_in,
    input  logic              c_in,
    output logic              allowin,
    output logic              validout,
    input  logic              rd_allow,
    output logic [WIDTH:0]    data_out,
    output logic [AW:0]       count,
    output logic              full,
    output logic              empty,
    input  logic              acc_clr,
    output logic [ACCW-1:0]   acc_out,
    output logic              acc_ovf
);

    localparam logic [AW:0] c_FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH:0]    r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [AW:0]       r_count;
    logic [ACCW-1:0]   r_acc;
    logic              r_ovf;

    logic              w_push;
    logic              w_pop;
    logic              w_flush;
    logic [ACCW-1:0]   w_addend;
    logic [ACCW:0]     w_acc_sum;

`ifdef RESBUF_FLUSH_EN
    assign w_flush = flush;
`else
    assign w_flush = 1'b0;
`endif

    // allowin depends only on registered occupancy, never on rd_allow
    assign full     = (r_count == c_FULL_CNT);
    assign empty    = (r_count == '0);
    assign allowin  = ~full;
    assign validout = ~empty;
    assign count    = r_count;
    assign data_out = r_mem[r_rd_ptr];

    assign w_push = validin & allowin;
    assign w_pop  = validout & rd_allow;

    assign w_addend  = {{(ACCW-WIDTH-1){1'b0}}, c_in, sum_in};
    assign w_acc_sum = {1'b0, r_acc} + {1'b0, w_addend};

    assign acc_out = r_acc;
    assign acc_ovf = r_ovf;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {c_in, sum_in};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (w_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Clear wins over accumulate; a push alongside a clear seeds the new sum
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_acc <= '0;
            r_ovf <= 1'b0;
        end else if (acc_clr && w_push) begin
            r_acc <= w_addend;
            r_ovf <= 1'b0;
        end else if (acc_clr) begin
            r_acc <= '0;
            r_ovf <= 1'b0;
        end else if (w_push) begin
            r_acc <= w_acc_sum[ACCW-1:0];
            r_ovf <= r_ovf | w_acc_sum[ACCW];
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_adder_result_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_adder_result_buffer
// Purpose  : Self-checking bench for adder_result_buffer against a queue and
//            integer-arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_adder_result_buffer;

    localparam int WIDTH = 32;
    localparam int DEPTH = 4;
    localparam int AW    = 2;
    localparam int ACCW  = 40;

    logic              clk;
    logic              rst;
    logic              validin;
    logic [WIDTH-1:0]  sum_in;
    logic              c_in;
    logic              allowin;
    logic              validout;
    logic              rd_allow;
    logic [WIDTH:0]    data_out;
    logic [AW:0]       count;
    logic              full;
    logic              empty;
    logic              acc_clr;
    logic [ACCW-1:0]   acc_out;
    logic              acc_ovf;

    adder_result_buffer #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW),
        .ACCW  (ACCW)
    ) u_dut (
        .clk      (clk),
        .rst      (rst),
        .validin  (validin),
        .sum_in   (sum_in),
        .c_in     (c_in),
        .allowin  (allowin),
        .validout (validout),
        .rd_allow (rd_allow),
        .data_out (data_out),
        .count    (count),
        .full     (full),
        .empty    (empty),
        .acc_clr  (acc_clr),
        .acc_out  (acc_out),
        .acc_ovf  (acc_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: contents as a queue, accumulator as plain integers
    logic [WIDTH:0]  m_q [$];
    logic [63:0]     m_acc;
    logic            m_ovf;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("count",    64'(count),    64'(m_q.size()));
        chk("empty",    64'(empty),    64'(m_q.size() == 0));
        chk("full",     64'(full),     64'(m_q.size() == DEPTH));
        chk("validout", 64'(validout), 64'(m_q.size() != 0));
        chk("allowin",  64'(allowin),  64'(m_q.size() != DEPTH));
        chk("acc_out",  64'(acc_out),  m_acc);
        chk("acc_ovf",  64'(acc_ovf),  64'(m_ovf));
        if (m_q.size() != 0) begin
            chk("data_out", 64'(data_out), 64'(m_q[0]));
        end
    endtask

    task automatic model_edge();
        logic        push;
        logic        pop;
        logic [63:0] val;
        logic [63:0] t;
        push = validin && (m_q.size() < DEPTH);
        pop  = rd_allow && (m_q.size() > 0);
        val  = 64'({c_in, sum_in});
        if (pop) void'(m_q.pop_front());
        if (push) m_q.push_back({c_in, sum_in});
        if (acc_clr && push) begin
            m_acc = val;
            m_ovf = 1'b0;
        end else if (acc_clr) begin
            m_acc = 64'd0;
            m_ovf = 1'b0;
        end else if (push) begin
            t     = m_acc + val;
            m_ovf = m_ovf | t[ACCW];
            m_acc = t & ((64'd1 << ACCW) - 64'd1);
        end
    endtask

    // Called at a negedge: drive inputs, take the edge, check at next negedge
    task automatic cycle(input logic v, input logic [WIDTH-1:0] s, input logic c,
                         input logic r, input logic clr);
        validin  = v;
        sum_in   = s;
        c_in     = c;
        rd_allow = r;
        acc_clr  = clr;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    initial begin
        rst      = 1'b0;
        validin  = 1'b0;
        sum_in   = '0;
        c_in     = 1'b0;
        rd_allow = 1'b0;
        acc_clr  = 1'b0;
        m_acc    = 64'd0;
        m_ovf    = 1'b0;

        // Reset held for two cycles
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        check_all();

        // Fill to full, refused fifth push, then drain in order
        cycle(1'b1, 32'd10, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 32'd20, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 32'd30, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 32'd40, 1'b0, 1'b0, 1'b0);
        chk("full_after_4", 64'(full), 64'd1);
        cycle(1'b1, 32'd50, 1'b0, 1'b0, 1'b0);
        chk("count_after_refused", 64'(count), 64'd4);
        chk("head_10", 64'(data_out), 64'd10);
        cycle(1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
        chk("head_20", 64'(data_out), 64'd20);
        cycle(1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
        chk("head_30", 64'(data_out), 64'd30);
        cycle(1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
        chk("head_40", 64'(data_out), 64'd40);
        cycle(1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
        chk("empty_after_drain", 64'(empty), 64'd1);
        cycle(1'b0, 32'd0, 1'b0, 1'b1, 1'b0);

        // Steady push/pop at count=2, pointers wrap
        cycle(1'b1, $urandom, 1'($urandom), 1'b0, 1'b0);
        cycle(1'b1, $urandom, 1'($urandom), 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            cycle(1'b1, $urandom, 1'($urandom), 1'b1, 1'b0);
            chk("count_steady_2", 64'(count), 64'd2);
        end
        cycle(1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
        cycle(1'b0, 32'd0, 1'b0, 1'b1, 1'b0);

        // Accumulator with carry
        cycle(1'b0, 32'd0, 1'b0, 1'b1, 1'b1);
        cycle(1'b1, 32'h0000_0005, 1'b1, 1'b1, 1'b0);
        chk("acc_carry_1", 64'(acc_out), 64'h1_0000_0005);
        cycle(1'b1, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0);
        chk("acc_carry_2", 64'(acc_out), 64'h2_0000_0004);

        // Overflow: 128 * 0x1_FFFF_FFFF + 0x70 = 0xFF_FFFF_FFF0
        cycle(1'b1, 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 127; i++) begin
            cycle(1'b1, 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b0);
        end
        cycle(1'b1, 32'h70, 1'b0, 1'b1, 1'b0);
        chk("acc_preload", 64'(acc_out), 64'hFF_FFFF_FFF0);
        chk("ovf_preload", 64'(acc_ovf), 64'd0);
        cycle(1'b1, 32'h20, 1'b0, 1'b1, 1'b0);
        chk("acc_wrap", 64'(acc_out), 64'h10);
        chk("ovf_set", 64'(acc_ovf), 64'd1);
        cycle(1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
        chk("ovf_sticky", 64'(acc_ovf), 64'd1);
        cycle(1'b1, 32'd7, 1'b0, 1'b1, 1'b1);
        chk("acc_clr_push", 64'(acc_out), 64'd7);
        chk("ovf_cleared", 64'(acc_ovf), 64'd0);

        // Randomised traffic
        for (int i = 0; i < 400; i++) begin
            cycle(1'($urandom_range(0, 3) != 0), $urandom, 1'($urandom),
                  1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 31) == 0));
        end
        cycle(1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
        while (m_q.size() != 0) cycle(1'b0, 32'd0, 1'b0, 1'b1, 1'b0);

        // Asynchronous reset with three entries held
        for (int i = 0; i < 3; i++) cycle(1'b1, $urandom, 1'b0, 1'b0, 1'b0);
        chk("count_pre_reset", 64'(count), 64'd3);
        validin = 1'b0;
        #1 rst = 1'b0;
        #1;
        chk("async_validout", 64'(validout), 64'd0);
        chk("async_count", 64'(count), 64'd0);
        chk("async_acc", 64'(acc_out), 64'd0);
        m_q.delete();
        m_acc = 64'd0;
        m_ovf = 1'b0;
        @(negedge clk);
        check_all();
        rst = 1'b1;
        cycle(1'b1, 32'h1234, 1'b0, 1'b0, 1'b0);
        chk("first_push_after_reset", 64'(count), 64'd1);
        cycle(1'b0, 32'd0, 1'b0, 1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Safety net so the run always ends
    initial begin
        #2000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
